// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control: issues ready-gated fetches, applies branch/JALR
// redirects (holding them while memory is busy), and raises the pipeline flushes.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       branchctrl,
    input  logic [31:0]      pc_ex,
    input  logic [31:0]      imm_ex,
    input  logic [31:0]      alu_out,
    input  logic             load_use_stall,
    input  logic             im_ready,
    output logic [31:0]      pc_o,
    output logic             im_req,
    output logic             fetch_valid,
    output logic [31:0]      fetch_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FETCH    = 2'b01,
        REDIRECT = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] pend_r;
    logic [31:0] pend_s;
    logic [31:0] target_s;
    logic        redirect_s;
    logic        take_s;

    // Redirect target selection; code 11 behaves like "no redirect".
    always_comb begin
        target_s   = 32'h0000_0000;
        redirect_s = 1'b0;
        case (branchctrl)
            2'b01: begin
                target_s   = pc_ex + imm_ex;
                redirect_s = 1'b1;
            end
            2'b10: begin
                target_s   = {alu_out[31:1], 1'b0};
                redirect_s = 1'b1;
            end
            default: begin
                target_s   = 32'h0000_0000;
                redirect_s = 1'b0;
            end
        endcase
    end

    // Redirects only count while a fetch stream is active (not in IDLE).
    assign take_s     = redirect_s && (state_r != IDLE);
    assign flush_ifid = take_s;
    assign flush_idex = take_s;
    assign pc_o       = pc_r;
    assign fetch_pc   = pc_r;

    // Next-state, next-PC and fetch handshake outputs.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        pend_s      = pend_r;
        im_req      = 1'b0;
        fetch_valid = 1'b0;
        case (state_r)
            IDLE: begin
                state_s = FETCH;
            end
            FETCH: begin
                im_req = 1'b1;
                if (redirect_s) begin
                    if (im_ready) begin
                        pc_s = target_s;
                    end else begin
                        pend_s  = target_s;
                        state_s = REDIRECT;
                    end
                end else if (load_use_stall) begin
                    pc_s = pc_r;
                end else if (im_ready) begin
                    fetch_valid = 1'b1;
                    pc_s        = pc_r + 32'd4;
                end else begin
                    pc_s = pc_r;
                end
            end
            REDIRECT: begin
                // The outstanding request keeps its address; its data is discarded.
                im_req = 1'b1;
                if (im_ready) begin
                    pc_s    = redirect_s ? target_s : pend_r;
                    state_s = FETCH;
                end else if (redirect_s) begin
                    pend_s = target_s;
                end else begin
                    pend_s = pend_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, PC, pending target, sticky misalignment flag and redirect counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            pend_r       <= 32'h0000_0000;
            misalign_err <= 1'b0;
            redirect_cnt <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            pend_r  <= pend_s;
            if (take_s) begin
                redirect_cnt <= redirect_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (take_s && (target_s[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: scenario tasks with inline checks and a
// scoreboard queue of expected fetch PCs consumed whenever fetch_valid is seen.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  branchctrl;
    logic [31:0] pc_ex;
    logic [31:0] imm_ex;
    logic [31:0] alu_out;
    logic        load_use_stall;
    logic        im_ready;
    logic [31:0] pc_o;
    logic        im_req;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misalign_err;
    logic [31:0] redirect_cnt;

    int          checks;
    int          errors;
    logic [31:0] exp_cnt;
    logic [31:0] sb[$];

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .branchctrl(branchctrl), .pc_ex(pc_ex), .imm_ex(imm_ex),
        .alu_out(alu_out), .load_use_stall(load_use_stall), .im_ready(im_ready),
        .pc_o(pc_o), .im_req(im_req), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .misalign_err(misalign_err),
        .redirect_cnt(redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted fetch must match the next expected PC.
    always @(negedge clk) begin
        if (fetch_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fetch fetch_pc=%h expected no fetch", fetch_pc);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (fetch_pc !== e) begin
                    errors++;
                    $display("FAIL fetch_pc got %h expected %h", fetch_pc, e);
                end
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] br, input logic [31:0] pe, input logic [31:0] im,
                       input logic [31:0] al, input logic st, input logic rdy);
        branchctrl     = br;
        pc_ex          = pe;
        imm_ex         = im;
        alu_out        = al;
        load_use_stall = st;
        im_ready       = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        adv();
        adv();
        @(negedge clk);
        checks++;
        if (pc_o !== 32'h0 || im_req !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs pc=%h req=%b fv=%b expected 0/0/0", pc_o, im_req, fetch_valid);
        end
        checks++;
        if (flush_ifid !== 1'b0 || flush_idex !== 1'b0 || misalign_err !== 1'b0 || redirect_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_flags fi=%b fd=%b mis=%b cnt=%0d expected all 0",
                     flush_ifid, flush_idex, misalign_err, redirect_cnt);
        end
        adv();
        rst = 1'b0;
        exp_cnt = 32'h0;
        @(negedge clk);
        checks++;
        if (im_req !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset req=%b fv=%b expected 0/0", im_req, fetch_valid);
        end
        for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
        adv();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (fetch_valid !== 1'b1 || pc_o !== 32'(i * 4)) begin
                errors++;
                $display("FAIL seq_fetch fv=%b pc=%h expected 1/%h", fetch_valid, pc_o, 32'(i * 4));
            end
            adv();
        end
    endtask

    task automatic test_redirect_rel();
        drv(2'b01, 32'h08, 32'h40, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b1 || fetch_valid !== 1'b0 || pc_o !== 32'h10) begin
            errors++;
            $display("FAIL rel_redirect fi=%b fd=%b fv=%b pc=%h expected 1/1/0/10",
                     flush_ifid, flush_idex, fetch_valid, pc_o);
        end
        exp_cnt++;
        adv();
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        sb.push_back(32'h48);
        @(negedge clk);
        checks++;
        if (pc_o !== 32'h48 || redirect_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL rel_target pc=%h cnt=%0d expected 48/%0d", pc_o, redirect_cnt, exp_cnt);
        end
        adv();
    endtask

    task automatic test_redirect_jalr();
        drv(2'b10, 32'h0, 32'h0, 32'h0000_0103, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (flush_ifid !== 1'b1 || fetch_valid !== 1'b0 || pc_o !== 32'h4C) begin
            errors++;
            $display("FAIL jalr_redirect fi=%b fv=%b pc=%h expected 1/0/4c", flush_ifid, fetch_valid, pc_o);
        end
        exp_cnt++;
        adv();
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (pc_o !== 32'h4C || fetch_valid !== 1'b0 || im_req !== 1'b1 || flush_ifid !== 1'b0) begin
                errors++;
                $display("FAIL jalr_hold pc=%h fv=%b req=%b fi=%b expected 4c/0/1/0",
                         pc_o, fetch_valid, im_req, flush_ifid);
            end
            adv();
        end
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (fetch_valid !== 1'b0 || pc_o !== 32'h4C) begin
            errors++;
            $display("FAIL jalr_discard fv=%b pc=%h expected 0/4c", fetch_valid, pc_o);
        end
        adv();
        // Next redirect (to 0x20) is applied in the same cycle the JALR target is checked.
        drv(2'b01, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (pc_o !== 32'h102 || misalign_err !== 1'b1 || redirect_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL jalr_target pc=%h mis=%b cnt=%0d expected 102/1/%0d",
                     pc_o, misalign_err, redirect_cnt, exp_cnt);
        end
        exp_cnt++;
        adv();
    endtask

    task automatic test_load_use_stall();
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (pc_o !== 32'h20 || fetch_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold pc=%h fv=%b expected 20/0", pc_o, fetch_valid);
            end
            adv();
        end
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        sb.push_back(32'h20);
        sb.push_back(32'h24);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (pc_o !== 32'(32'h20 + i * 4) || fetch_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_release pc=%h fv=%b expected %h/1", pc_o, fetch_valid, 32'(32'h20 + i * 4));
            end
            adv();
        end
    endtask

    task automatic test_priority();
        drv(2'b01, 32'h80, 32'h0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (flush_ifid !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_flush fi=%b fv=%b expected 1/0", flush_ifid, fetch_valid);
        end
        exp_cnt++;
        adv();
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        sb.push_back(32'h80);
        @(negedge clk);
        checks++;
        if (pc_o !== 32'h80 || redirect_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL prio_target pc=%h cnt=%0d expected 80/%0d", pc_o, redirect_cnt, exp_cnt);
        end
        adv();
    endtask

    task automatic test_back_to_back();
        drv(2'b01, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        exp_cnt++;
        adv();
        // A second redirect while waiting replaces the pending target; stall is ignored.
        drv(2'b10, 32'h0, 32'h0, 32'h400, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (flush_idex !== 1'b1 || im_req !== 1'b1 || fetch_valid !== 1'b0 || pc_o !== 32'h84) begin
            errors++;
            $display("FAIL b2b_wait fd=%b req=%b fv=%b pc=%h expected 1/1/0/84",
                     flush_idex, im_req, fetch_valid, pc_o);
        end
        exp_cnt++;
        adv();
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (fetch_valid !== 1'b0 || pc_o !== 32'h84) begin
            errors++;
            $display("FAIL b2b_complete fv=%b pc=%h expected 0/84", fetch_valid, pc_o);
        end
        adv();
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        sb.push_back(32'h400);
        @(negedge clk);
        checks++;
        if (pc_o !== 32'h400 || redirect_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_target pc=%h cnt=%0d expected 400/%0d", pc_o, redirect_cnt, exp_cnt);
        end
        adv();
    endtask

    task automatic test_wrap();
        // 0x10 + (-20) wraps to 0xFFFF_FFFC; the following sequential fetch wraps to 0.
        drv(2'b01, 32'h10, 32'hFFFF_FFEC, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        exp_cnt++;
        adv();
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        sb.push_back(32'hFFFF_FFFC);
        sb.push_back(32'h0);
        @(negedge clk);
        checks++;
        if (pc_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL add_wrap pc=%h expected fffffffc", pc_o);
        end
        adv();
        @(negedge clk);
        checks++;
        if (pc_o !== 32'h0) begin
            errors++;
            $display("FAIL seq_wrap pc=%h expected 0", pc_o);
        end
        adv();
    endtask

    task automatic test_reset_in_redirect();
        drv(2'b01, 32'h200, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        exp_cnt++;
        adv();
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (im_req !== 1'b1 || pc_o !== 32'h4 || redirect_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL pre_reset req=%b pc=%h cnt=%0d expected 1/4/%0d", im_req, pc_o, redirect_cnt, exp_cnt);
        end
        adv();
        @(negedge clk);
        checks++;
        if (pc_o !== 32'h0 || im_req !== 1'b0 || redirect_cnt !== 32'h0 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset pc=%h req=%b cnt=%0d mis=%b expected 0/0/0/0",
                     pc_o, im_req, redirect_cnt, misalign_err);
        end
        adv();
        rst = 1'b0;
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        @(negedge clk);
        checks++;
        if (im_req !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle req=%b expected 0", im_req);
        end
        adv();
        adv();
        adv();
        drv(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (pc_o !== 32'h8) begin
            errors++;
            $display("FAIL post_reset_seq pc=%h expected 8", pc_o);
        end
        adv();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 32'h0;
        test_reset();
        test_redirect_rel();
        test_redirect_jalr();
        test_load_use_stall();
        test_priority();
        test_back_to_back();
        test_wrap();
        test_reset_in_redirect();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
